lane_gene_serializer: RTL and testbench
=======================================

Name: lane_gene_serializer

Overview:
Sits directly downstream of the add-node lane stage. It accepts up to three genes per cycle, qualified by a 3-bit valid mask (gene1/gene2/gene3 from the mutation stage). It packs them in order into an internal FIFO and drains them as a single-gene ready/valid stream to the genome memory writer. It also marks genome boundaries and counts the genes emitted per genome.

Parameters:
GENE_SZ, 64, width of one gene word
ATTR_SZ, 8, width of gene_count
DEPTH, 8, FIFO entries (must be at least 4)
LVL_W, 4, width of fill_level (must hold 0..DEPTH)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous reset, active-high
in_gene1  in  GENE_SZ  first candidate gene
in_gene2  in  GENE_SZ  second candidate gene
in_gene3  in  GENE_SZ  third candidate gene
in_valid  in  3  bit0/1/2 qualify gene1/2/3
in_last  in  1  current group ends the genome
in_ready  out  1  room for a full 3-gene group
out_gene  out  GENE_SZ  head-of-FIFO gene
out_valid  out  1  FIFO not empty
out_last  out  1  head gene ends a genome
out_ready  in  1  downstream accepts out_gene
gene_count  out  ATTR_SZ  genes popped in the current genome
fill_level  out  LVL_W  current FIFO occupancy
overflow_err  out  1  sticky: a group was offered while in_ready was low

Behaviour:
- Clock and reset: single clock, clk. rst is synchronous and active-high; it is sampled only on the posedge of clk.
- Reset: FIFO emptied and pointers set to 0. fill_level=0, out_valid=0, out_gene=0, out_last=0, in_ready=1, gene_count=0, overflow_err=0. Reset asserted mid-operation discards all stored genes on that edge.
- Storage: DEPTH entries of {last, gene}. Read and write pointers wrap modulo DEPTH. An occupancy register drives fill_level.
- in_ready: combinational from the registered occupancy, in_ready = (fill_level <= DEPTH-3). It never depends on in_valid.
- Push:
  - A push occurs when in_ready=1 and in_valid!=0.
  - Valid genes are written in order gene1, gene2, gene3, skipping bits that are 0, into consecutive slots. Example: mask 3'b101 writes gene1 then gene3 (2 entries).
  - n_push is the popcount of in_valid (0..3).
  - in_last is sampled only on a push. It sets the last flag on the final written gene of the group only.
  - in_valid=0 is a no-op; in_last is ignored in that case.
- Overflow: in_valid!=0 while in_ready=0 drops the whole group. FIFO contents are unchanged. overflow_err is set and stays high until rst.
- Pop:
  - out_valid = (fill_level != 0).
  - out_gene and out_last reflect the head entry combinationally from storage. When empty, out_gene=0 and out_last=0.
  - A pop occurs when out_valid=1 and out_ready=1; the read pointer advances by 1.
- Simultaneous push and pop: next occupancy = fill_level + n_push - pop. A push into an empty FIFO becomes visible on out_valid the next cycle (one-cycle latency); there is no same-cycle bypass.
- gene_count:
  - Increments by 1 on each pop of a non-last gene, saturating at 2^ATTR_SZ-1.
  - On a pop of a gene with last=1 it loads 0, marking the start of the next genome.
  - Popping while empty is impossible; out_ready with out_valid=0 has no effect.
- Ordering: FIFO order is strict. Genes from consecutive groups are never interleaved or reordered.
- Pointer wrap: correct across the DEPTH boundary within a single group. Example: with a write pointer of DEPTH-1, a 3-gene group writes slots DEPTH-1, 0, 1.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=3'b111 -> fill_level=0, out_valid=0, in_ready=1, no entries are written.
- Pass-through group: in_valid=3'b111, genes A/B/C, in_last=1, out_ready=1 -> out_gene A, B, C on the following 3 cycles; out_last=1 only with C; gene_count goes 0 -> 1 -> 2 -> 0.
- Sparse mask: in_valid=3'b101 (genes D, -, F) -> fill_level=2; output order D then F.
- Backpressure and overflow (DEPTH=8, out_ready=0):
  - Two 3-gene groups -> fill_level=6, in_ready=0.
  - Offer a third group -> it is dropped, overflow_err=1, fill_level stays 6.
  - Release out_ready -> exactly 6 genes drain in order.
- Wrap and simultaneous traffic: prefill 6 and drain 5 so the pointers sit near DEPTH-1. Then push 3 while popping 1 every cycle for 10 cycles -> no loss or duplication, and fill_level tracks +2 per cycle until in_ready falls.
- Mid-stream reset: with 5 genes stored, pulse rst for 1 cycle -> out_valid=0 on the next cycle and gene_count=0; a subsequent group emits normally.

Source files
------------

// File: rtl/lane_gene_serializer.sv
// ============================================================================
// Module   : lane_gene_serializer
// Brief    : Packs up to three valid genes per cycle into a FIFO and drains
//            them one per cycle with genome-boundary marking and counting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_gene_serializer #(
    parameter int GENE_SZ = 64,
    parameter int ATTR_SZ = 8,
    parameter int DEPTH   = 8,
    parameter int LVL_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [GENE_SZ-1:0] in_gene1,
    input  logic [GENE_SZ-1:0] in_gene2,
    input  logic [GENE_SZ-1:0] in_gene3,
    input  logic [2:0]         in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [GENE_SZ-1:0] out_gene,
    output logic               out_valid,
    output logic               out_last,
    input  logic               out_ready,
    output logic [ATTR_SZ-1:0] gene_count,
    output logic [LVL_W-1:0]   fill_level,
    output logic               overflow_err
);

    localparam int                PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]    C_DEPTH     = (PTR_W + 1)'(DEPTH);
    localparam logic [LVL_W-1:0]  C_READY_MAX = LVL_W'(DEPTH - 3);
    localparam logic [ATTR_SZ-1:0] C_CNT_MAX  = '1;

    // Storage and control state
    logic [GENE_SZ-1:0] mem_gene_q [DEPTH];
    logic [GENE_SZ-1:0] mem_gene_d [DEPTH];
    logic               mem_last_q [DEPTH];
    logic               mem_last_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   fill_q, fill_d;
    logic [ATTR_SZ-1:0] gene_count_q, gene_count_d;
    logic               overflow_err_q, overflow_err_d;

    logic               w_any_valid;
    logic               w_push;
    logic               w_pop;
    logic               w_out_valid;
    logic               w_head_last;
    logic [1:0]         w_n_push;
    logic [GENE_SZ-1:0] w_slot_gene [3];
    logic               w_slot_last [3];
    logic [PTR_W-1:0]   w_slot_idx  [3];

    // Modular pointer advance; n <= 3 < DEPTH so one subtraction suffices.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input logic [1:0]       n);
        logic [PTR_W:0] s;
        s = {1'b0, p} + (PTR_W + 1)'(n);
        if (s >= C_DEPTH) begin
            s = s - C_DEPTH;
        end
        return s[PTR_W-1:0];
    endfunction

    assign w_any_valid = |in_valid;
    assign in_ready    = (fill_q <= C_READY_MAX);
    assign w_push      = in_ready && w_any_valid;
    assign w_out_valid = (fill_q != '0);
    assign w_pop       = w_out_valid && out_ready;
    assign w_n_push    = 2'(in_valid[0]) + 2'(in_valid[1]) + 2'(in_valid[2]);

    // Compact the masked genes into consecutive slots, preserving order.
    always_comb begin
        w_slot_gene[0] = in_valid[0] ? in_gene1 : (in_valid[1] ? in_gene2 : in_gene3);
        w_slot_gene[1] = (in_valid[0] && in_valid[1]) ? in_gene2 : in_gene3;
        w_slot_gene[2] = in_gene3;
        for (int j = 0; j < 3; j++) begin
            w_slot_last[j] = in_last && (2'(j) == (w_n_push - 2'd1));
            w_slot_idx[j]  = ptr_add(wr_ptr_q, 2'(j));
        end
    end

    always_comb begin
        mem_gene_d = mem_gene_q;
        mem_last_d = mem_last_q;
        if (w_push) begin
            for (int j = 0; j < 3; j++) begin
                if (2'(j) < w_n_push) begin
                    mem_gene_d[w_slot_idx[j]] = w_slot_gene[j];
                    mem_last_d[w_slot_idx[j]] = w_slot_last[j];
                end
            end
        end
    end

    always_comb begin
        wr_ptr_d = w_push ? ptr_add(wr_ptr_q, w_n_push) : wr_ptr_q;
        rd_ptr_d = w_pop  ? ptr_add(rd_ptr_q, 2'd1)     : rd_ptr_q;

        fill_d = fill_q;
        if (w_push) begin
            fill_d = fill_d + LVL_W'(w_n_push);
        end
        if (w_pop) begin
            fill_d = fill_d - LVL_W'(1);
        end

        gene_count_d = gene_count_q;
        if (w_pop) begin
            if (w_head_last) begin
                gene_count_d = '0;
            end else if (gene_count_q != C_CNT_MAX) begin
                gene_count_d = gene_count_q + ATTR_SZ'(1);
            end
        end

        overflow_err_d = overflow_err_q || (w_any_valid && !in_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_gene_q[e] <= '0;
                mem_last_q[e] <= 1'b0;
            end
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fill_q         <= '0;
            gene_count_q   <= '0;
            overflow_err_q <= 1'b0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_gene_q[e] <= mem_gene_d[e];
                mem_last_q[e] <= mem_last_d[e];
            end
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fill_q         <= fill_d;
            gene_count_q   <= gene_count_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    // Head entry is shown only while occupied; an empty FIFO presents zeros.
    assign w_head_last  = mem_last_q[rd_ptr_q];
    assign out_valid    = w_out_valid;
    assign out_gene     = w_out_valid ? mem_gene_q[rd_ptr_q] : '0;
    assign out_last     = w_out_valid && w_head_last;
    assign gene_count   = gene_count_q;
    assign fill_level   = fill_q;
    assign overflow_err = overflow_err_q;

endmodule

`default_nettype wire

// File: tb/tb_lane_gene_serializer.sv
// ============================================================================
// Module   : tb_lane_gene_serializer
// Brief    : Directed self-checking bench for lane_gene_serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lane_gene_serializer;

    localparam int GENE_SZ = 64;
    localparam int ATTR_SZ = 8;
    localparam int DEPTH   = 8;
    localparam int LVL_W   = 4;

    logic               clk;
    logic               rst;
    logic [GENE_SZ-1:0] in_gene1, in_gene2, in_gene3;
    logic [2:0]         in_valid;
    logic               in_last;
    logic               in_ready;
    logic [GENE_SZ-1:0] out_gene;
    logic               out_valid;
    logic               out_last;
    logic               out_ready;
    logic [ATTR_SZ-1:0] gene_count;
    logic [LVL_W-1:0]   fill_level;
    logic               overflow_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_gc = 0;
    logic [GENE_SZ-1:0] exp_q [$];

    lane_gene_serializer #(
        .GENE_SZ(GENE_SZ), .ATTR_SZ(ATTR_SZ), .DEPTH(DEPTH), .LVL_W(LVL_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_gene1(in_gene1), .in_gene2(in_gene2), .in_gene3(in_gene3),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_gene(out_gene), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .gene_count(gene_count),
        .fill_level(fill_level), .overflow_err(overflow_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 3'b111; in_last = 1'b1; out_ready = 1'b0;
        in_gene1 = 64'h1111; in_gene2 = 64'h2222; in_gene3 = 64'h3333;
        step(); step();
        n_cmp++; if (fill_level !== 4'd0) begin n_fail++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_gene !== 64'h0) begin n_fail++; $display("FAIL reset_out_gene: got %h want 0", out_gene); end
        n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        n_cmp++; if (gene_count !== 8'd0) begin n_fail++; $display("FAIL reset_gene_count: got %0d want 0", gene_count); end
        n_cmp++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow_err); end
        rst = 1'b0; in_valid = 3'b000; in_last = 1'b0;
        step();
        n_cmp++; if (fill_level !== 4'd0) begin n_fail++; $display("FAIL reset_no_write: got %0d want 0", fill_level); end
    endtask

    task automatic test_pass_through();
        in_gene1 = 64'hAAAA_0000_0000_000A; in_gene2 = 64'hBBBB_0000_0000_000B;
        in_gene3 = 64'hCCCC_0000_0000_000C;
        in_valid = 3'b111; in_last = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 3'b000; in_last = 1'b0;
        n_cmp++; if (fill_level !== 4'd3) begin n_fail++; $display("FAIL pass_fill: got %0d want 3", fill_level); end
        n_cmp++; if (out_gene !== 64'hAAAA_0000_0000_000A || out_last !== 1'b0) begin n_fail++; $display("FAIL pass_A: got %h/%b want aaaa00000000000a/0", out_gene, out_last); end
        n_cmp++; if (gene_count !== 8'd0) begin n_fail++; $display("FAIL pass_gc0: got %0d want 0", gene_count); end
        step();
        n_cmp++; if (out_gene !== 64'hBBBB_0000_0000_000B || out_last !== 1'b0) begin n_fail++; $display("FAIL pass_B: got %h/%b want bbbb00000000000b/0", out_gene, out_last); end
        n_cmp++; if (gene_count !== 8'd1) begin n_fail++; $display("FAIL pass_gc1: got %0d want 1", gene_count); end
        step();
        n_cmp++; if (out_gene !== 64'hCCCC_0000_0000_000C || out_last !== 1'b1) begin n_fail++; $display("FAIL pass_C: got %h/%b want cccc00000000000c/1", out_gene, out_last); end
        n_cmp++; if (gene_count !== 8'd2) begin n_fail++; $display("FAIL pass_gc2: got %0d want 2", gene_count); end
        step();
        n_cmp++; if (out_valid !== 1'b0 || fill_level !== 4'd0) begin n_fail++; $display("FAIL pass_empty: got valid %b fill %0d want 0/0", out_valid, fill_level); end
        n_cmp++; if (gene_count !== 8'd0) begin n_fail++; $display("FAIL pass_gc_end: got %0d want 0", gene_count); end
    endtask

    task automatic test_sparse_mask();
        out_ready = 1'b0;
        in_gene1 = 64'hDDDD; in_gene2 = 64'hEEEE; in_gene3 = 64'hFFFF;
        in_valid = 3'b101; in_last = 1'b1;
        step();
        in_valid = 3'b000; in_last = 1'b0;
        n_cmp++; if (fill_level !== 4'd2) begin n_fail++; $display("FAIL sparse_fill: got %0d want 2", fill_level); end
        n_cmp++; if (out_gene !== 64'hDDDD || out_last !== 1'b0) begin n_fail++; $display("FAIL sparse_D: got %h/%b want dddd/0", out_gene, out_last); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_gene !== 64'hFFFF || out_last !== 1'b1) begin n_fail++; $display("FAIL sparse_F: got %h/%b want ffff/1", out_gene, out_last); end
        n_cmp++; if (gene_count !== 8'd1) begin n_fail++; $display("FAIL sparse_gc: got %0d want 1", gene_count); end
        step();
        n_cmp++; if (out_valid !== 1'b0 || out_gene !== 64'h0 || out_last !== 1'b0) begin n_fail++; $display("FAIL sparse_empty: got %b/%h/%b want 0/0/0", out_valid, out_gene, out_last); end
        n_cmp++; if (gene_count !== 8'd0) begin n_fail++; $display("FAIL sparse_gc_end: got %0d want 0", gene_count); end
        exp_gc = 0;
    endtask

    // Prefill 6, drain 5, then push 3 / pop 1 per cycle so groups straddle the wrap.
    task automatic test_wrap_traffic();
        int mfill;
        int seq;
        logic [GENE_SZ-1:0] g;
        out_ready = 1'b0; in_last = 1'b0; seq = 0;
        exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            in_gene1 = 64'h5EED_0000_0000_0000 + 64'(seq);
            in_gene2 = 64'h5EED_0000_0000_0000 + 64'(seq + 1);
            in_gene3 = 64'h5EED_0000_0000_0000 + 64'(seq + 2);
            exp_q.push_back(in_gene1); exp_q.push_back(in_gene2); exp_q.push_back(in_gene3);
            seq += 3;
            in_valid = 3'b111;
            step();
        end
        in_valid = 3'b000;
        n_cmp++; if (fill_level !== 4'd6) begin n_fail++; $display("FAIL wrap_prefill: got %0d want 6", fill_level); end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            g = exp_q.pop_front();
            n_cmp++; if (out_gene !== g) begin n_fail++; $display("FAIL wrap_drain%0d: got %h want %h", k, out_gene, g); end
            exp_gc++;
            step();
        end
        mfill = 1;
        for (int c = 0; c < 10; c++) begin
            n_cmp++; if (fill_level !== LVL_W'(mfill)) begin n_fail++; $display("FAIL wrap_fill_c%0d: got %0d want %0d", c, fill_level, mfill); end
            n_cmp++; if (in_ready !== (mfill <= DEPTH - 3)) begin n_fail++; $display("FAIL wrap_ready_c%0d: got %b want %b", c, in_ready, (mfill <= DEPTH - 3)); end
            g = exp_q.pop_front();
            n_cmp++; if (out_gene !== g) begin n_fail++; $display("FAIL wrap_gene_c%0d: got %h want %h", c, out_gene, g); end
            exp_gc++;
            mfill--;
            if (mfill + 1 <= DEPTH - 3) begin
                in_gene1 = 64'hC0DE_0000_0000_0000 + 64'(seq);
                in_gene2 = 64'hC0DE_0000_0000_0000 + 64'(seq + 1);
                in_gene3 = 64'hC0DE_0000_0000_0000 + 64'(seq + 2);
                exp_q.push_back(in_gene1); exp_q.push_back(in_gene2); exp_q.push_back(in_gene3);
                seq += 3; mfill += 3;
                in_valid = 3'b111;
            end else begin
                in_valid = 3'b000;
            end
            step();
        end
        in_valid = 3'b000;
        for (int k = 0; k < 20; k++) begin
            if (exp_q.size() > 0) begin
                g = exp_q.pop_front();
                n_cmp++; if (out_gene !== g || out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_tail%0d: got %h/%b want %h/1", k, out_gene, out_valid, g); end
                exp_gc++;
                step();
            end
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: got %b want 0", out_valid); end
        n_cmp++; if (gene_count !== ATTR_SZ'(exp_gc)) begin n_fail++; $display("FAIL wrap_gc: got %0d want %0d", gene_count, exp_gc); end
        n_cmp++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL wrap_no_overflow: got %b want 0", overflow_err); end
    endtask

    task automatic test_overflow();
        logic [GENE_SZ-1:0] g;
        out_ready = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            in_gene1 = 64'h6000 + 64'(3 * k);
            in_gene2 = 64'h6000 + 64'(3 * k + 1);
            in_gene3 = 64'h6000 + 64'(3 * k + 2);
            exp_q.push_back(in_gene1); exp_q.push_back(in_gene2); exp_q.push_back(in_gene3);
            in_valid = 3'b111; in_last = (k == 1);
            step();
        end
        in_valid = 3'b000; in_last = 1'b0;
        n_cmp++; if (fill_level !== 4'd6 || in_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_full: got fill %0d ready %b want 6/0", fill_level, in_ready); end
        n_cmp++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got %b want 0", overflow_err); end
        in_gene1 = 64'hBAD1; in_gene2 = 64'hBAD2; in_gene3 = 64'hBAD3; in_valid = 3'b111;
        step();
        in_valid = 3'b000;
        n_cmp++; if (fill_level !== 4'd6) begin n_fail++; $display("FAIL ovf_dropped: got %0d want 6", fill_level); end
        n_cmp++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow_err); end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            g = exp_q.pop_front();
            n_cmp++; if (out_gene !== g || out_last !== (i == 5)) begin n_fail++; $display("FAIL ovf_drain%0d: got %h/%b want %h/%b", i, out_gene, out_last, g, (i == 5)); end
            n_cmp++; if (gene_count !== ATTR_SZ'(exp_gc)) begin n_fail++; $display("FAIL ovf_gc%0d: got %0d want %0d", i, gene_count, exp_gc); end
            exp_gc = (i == 5) ? 0 : exp_gc + 1;
            step();
        end
        n_cmp++; if (out_valid !== 1'b0 || gene_count !== 8'd0) begin n_fail++; $display("FAIL ovf_end: got valid %b gc %0d want 0/0", out_valid, gene_count); end
        n_cmp++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow_err); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0; in_last = 1'b0;
        in_gene1 = 64'h7001; in_gene2 = 64'h7002; in_gene3 = 64'h7003; in_valid = 3'b111;
        step();
        in_gene1 = 64'h7004; in_gene2 = 64'h7005; in_valid = 3'b011;
        step();
        in_valid = 3'b000;
        n_cmp++; if (fill_level !== 4'd5) begin n_fail++; $display("FAIL mid_fill5: got %0d want 5", fill_level); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (gene_count !== 8'd1 || fill_level !== 4'd4) begin n_fail++; $display("FAIL mid_prepop: got gc %0d fill %0d want 1/4", gene_count, fill_level); end
        rst = 1'b1; in_valid = 3'b111;
        step();
        rst = 1'b0; in_valid = 3'b000; out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || fill_level !== 4'd0) begin n_fail++; $display("FAIL mid_flushed: got valid %b fill %0d want 0/0", out_valid, fill_level); end
        n_cmp++; if (gene_count !== 8'd0 || overflow_err !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_regs: got gc %0d ovf %b ready %b want 0/0/1", gene_count, overflow_err, in_ready); end
        in_gene1 = 64'h8001; in_gene2 = 64'h8002; in_gene3 = 64'h8003;
        in_valid = 3'b111; in_last = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 3'b000; in_last = 1'b0;
        n_cmp++; if (out_gene !== 64'h8001 || out_last !== 1'b0 || fill_level !== 4'd3) begin n_fail++; $display("FAIL mid_N0: got %h/%b fill %0d want 8001/0 fill 3", out_gene, out_last, fill_level); end
        step();
        n_cmp++; if (out_gene !== 64'h8002 || gene_count !== 8'd1) begin n_fail++; $display("FAIL mid_N1: got %h gc %0d want 8002 gc 1", out_gene, gene_count); end
        step();
        n_cmp++; if (out_gene !== 64'h8003 || out_last !== 1'b1 || gene_count !== 8'd2) begin n_fail++; $display("FAIL mid_N2: got %h/%b gc %0d want 8003/1 gc 2", out_gene, out_last, gene_count); end
        step();
        n_cmp++; if (out_valid !== 1'b0 || gene_count !== 8'd0) begin n_fail++; $display("FAIL mid_end: got valid %b gc %0d want 0/0", out_valid, gene_count); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 3'b000; in_last = 1'b0; out_ready = 1'b0;
        in_gene1 = '0; in_gene2 = '0; in_gene3 = '0;
        test_reset();
        test_pass_through();
        test_sparse_mask();
        test_wrap_traffic();
        test_overflow();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
